monolith_sponge: RTL
====================

MONOLITH_SPONGE -- requirements
Module: monolith_sponge

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
 WORD_WIDTH, 31, field element width; modulus p = 2^31-1.
 STATE_SIZE, 16, permutation state words.
 RATE, 8, absorbed/squeezed words per block, 1..STATE_SIZE-1; words RATE..STATE_SIZE-1 are capacity.
 DIGEST_WORDS, 8, squeezed words per message, 1..RATE.
REQ-002 Ports SHALL be, one per line: name direction width meaning.
 clk in 1 clock, all logic on rising edge.
 reset in 1 synchronous active-high reset.
 in_data in WORD_WIDTH message word, canonical (< p).
 in_valid in 1 message word present.
 in_last in 1 marks final word of message.
 in_ready out 1 block accepts a word.
 perm_state_out out WORD_WIDTH x STATE_SIZE state to permutation.
 perm_in_valid out 1 one-cycle permutation start strobe.
 perm_state_in in WORD_WIDTH x STATE_SIZE permuted state.
 perm_out_valid in 1 permuted state valid.
 out_data out WORD_WIDTH digest word.
 out_valid out 1 digest word present.
 out_last out 1 final digest word.
 out_ready in 1 consumer accepts digest word.
 busy out 1 high in any state except ABSORB with word index 0 and zero state.

Function
REQ-003 The block SHALL implement a field sponge around an externally instantiated monolith_hash with FSM states ABSORB, PAD, PERM_ISSUE, PERM_WAIT, SQUEEZE.
REQ-004 Word transfer SHALL occur when in_valid and in_ready are both high; in_ready SHALL be high only in ABSORB.
REQ-005 On transfer, state[idx] SHALL become (state[idx] + in_data) mod p: 32-bit sum, subtract p when sum >= p; idx then increments.
REQ-006 Transfer with idx = RATE-1 and in_last low -> PERM_ISSUE, idx <= 0.
REQ-007 Transfer with in_last high SHALL set flag fin; idx < RATE-1 -> PAD with idx+1; idx = RATE-1 -> PERM_ISSUE, idx <= 0, pad still pending.
REQ-008 PAD SHALL, in one cycle, add 1 mod p to state[idx], set flag padded, and go to PERM_ISSUE.
REQ-009 PERM_ISSUE SHALL drive perm_in_valid high for exactly one cycle with perm_state_out = current state, then go to PERM_WAIT; perm_state_out SHALL equal the state register in every state.
REQ-010 In PERM_WAIT, on perm_out_valid the state SHALL load perm_state_in; next state: padded -> SQUEEZE; fin and not padded -> PAD with idx 0; otherwise ABSORB.
REQ-011 perm_out_valid in any state other than PERM_WAIT SHALL be ignored; permutation latency is unbounded from the block's view.
REQ-012 SQUEEZE SHALL assert out_valid with out_data = state[oidx], out_last high when oidx = DIGEST_WORDS-1; out_data, out_last SHALL hold stable while out_valid high and out_ready low.
REQ-013 On the out_last handshake the state SHALL clear to zero, idx, oidx, fin, padded clear, FSM -> ABSORB next cycle.
REQ-014 Only one permutation SHALL be outstanding; no new input is accepted before the digest is fully drained.

Reset
REQ-015 reset SHALL, regardless of state, set state registers to zero, FSM ABSORB, idx = oidx = 0, fin = padded = 0.
REQ-016 Reset values: in_ready 1, perm_in_valid 0, out_valid 0, out_last 0, out_data 0, busy 0, perm_state_out all zero.
REQ-017 A perm_out_valid arriving after a mid-permutation reset SHALL not alter state.

Verification
REQ-018 Reset, idle inputs -> in_ready=1, out_valid=0, perm_in_valid=0, busy=0 for 10 cycles.
REQ-019 Single word 5 with in_last -> one perm_in_valid pulse with perm_state_out = [5,1,0,...,0]; model returns S -> out_data S[0]..S[7], out_last on 8th only.
REQ-020 Words 1..8, in_last on 8 -> first pulse with [1..8,0,...,0]; model returns S1 -> second pulse with S1 except word0 = S1[0]+1 mod p; then squeeze.
REQ-021 Modular wrap: state[0] = 0x7FFFFFFE from model, next block first word 3 -> state[0] = 0x00000002.
REQ-022 out_ready low 5 cycles in SQUEEZE -> out_data and out_last stable, in_ready=0; resume -> remaining words in order.
REQ-023 reset during PERM_WAIT, then perm_out_valid with nonzero state -> perm_state_out stays zero, FSM ABSORB, in_ready=1.

Source files
------------

// File: rtl/monolith_sponge_if.sv
// Handshake and permutation bus between monolith_sponge and its environment.
// slave is the sponge's view; master is the driver/permutation side.
interface monolith_sponge_if #(
   parameter int WORD_WIDTH = 31,
   parameter int STATE_SIZE = 16
);
   logic [WORD_WIDTH-1:0]                  in_data;
   logic                                   in_valid;
   logic                                   in_last;
   logic                                   in_ready;
   logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]  perm_state_out;
   logic                                   perm_in_valid;
   logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]  perm_state_in;
   logic                                   perm_out_valid;
   logic [WORD_WIDTH-1:0]                  out_data;
   logic                                   out_valid;
   logic                                   out_last;
   logic                                   out_ready;
   logic                                   busy;

   modport slave (
      input  in_data, in_valid, in_last, perm_state_in, perm_out_valid, out_ready,
      output in_ready, perm_state_out, perm_in_valid, out_data, out_valid, out_last, busy
   );

   modport master (
      output in_data, in_valid, in_last, perm_state_in, perm_out_valid, out_ready,
      input  in_ready, perm_state_out, perm_in_valid, out_data, out_valid, out_last, busy
   );
endinterface

// File: rtl/monolith_sponge.sv
// Field sponge over GF(2^31-1) wrapped around an external monolith permutation.
// Absorbs RATE words per block, pads with a single 1 word, squeezes DIGEST_WORDS words.
//
// state      | meaning
// ABSORB     | accept message words into state[idx]
// PAD        | add 1 to state[idx] after the final word
// PERM_ISSUE | one-cycle start strobe to the permutation
// PERM_WAIT  | wait for permuted state, then decide next phase
// SQUEEZE    | present state[oidx] as digest words
module monolith_sponge #(
   parameter int WORD_WIDTH   = 31,
   parameter int STATE_SIZE   = 16,
   parameter int RATE         = 8,
   parameter int DIGEST_WORDS = 8
) (
   input logic              clk,
   input logic              reset,
   monolith_sponge_if.slave bus
);
   localparam int                  IDX_W     = $clog2(STATE_SIZE);
   localparam logic [WORD_WIDTH:0] P         = {1'b0, {WORD_WIDTH{1'b1}}};
   localparam logic [IDX_W-1:0]    RATE_LAST = IDX_W'(RATE - 1);
   localparam logic [IDX_W-1:0]    DIG_LAST  = IDX_W'(DIGEST_WORDS - 1);

   typedef enum logic [2:0] {
      ABSORB,
      PAD,
      PERM_ISSUE,
      PERM_WAIT,
      SQUEEZE
   } fsm_t;

   typedef logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_t;

   fsm_t             fsm_q, fsm_d;
   state_t           st_q, st_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] oidx_q, oidx_d;
   logic             fin_q, fin_d;
   logic             padded_q, padded_d;

   // Both operands are canonical, so one conditional subtraction suffices.
   function automatic logic [WORD_WIDTH-1:0] mod_add(input logic [WORD_WIDTH-1:0] a,
                                                     input logic [WORD_WIDTH-1:0] b);
      logic [WORD_WIDTH:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= P) begin
         sum = sum - P;
      end
      return sum[WORD_WIDTH-1:0];
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_q    <= ABSORB;
         st_q     <= '0;
         idx_q    <= '0;
         oidx_q   <= '0;
         fin_q    <= 1'b0;
         padded_q <= 1'b0;
      end else begin
         fsm_q    <= fsm_d;
         st_q     <= st_d;
         idx_q    <= idx_d;
         oidx_q   <= oidx_d;
         fin_q    <= fin_d;
         padded_q <= padded_d;
      end
   end

   always_comb begin
      fsm_d    = fsm_q;
      st_d     = st_q;
      idx_d    = idx_q;
      oidx_d   = oidx_q;
      fin_d    = fin_q;
      padded_d = padded_q;
      case (fsm_q)
         ABSORB: begin
            if (bus.in_valid) begin
               st_d[idx_q] = mod_add(st_q[idx_q], bus.in_data);
               if (bus.in_last) begin
                  fin_d = 1'b1;
               end
               // A last word that fills the block leaves the pad for a fresh block.
               if (idx_q == RATE_LAST) begin
                  idx_d = '0;
                  fsm_d = PERM_ISSUE;
               end else begin
                  idx_d = idx_q + 1'b1;
                  if (bus.in_last) begin
                     fsm_d = PAD;
                  end
               end
            end
         end
         PAD: begin
            st_d[idx_q] = mod_add(st_q[idx_q], WORD_WIDTH'(1));
            padded_d    = 1'b1;
            fsm_d       = PERM_ISSUE;
         end
         PERM_ISSUE: begin
            fsm_d = PERM_WAIT;
         end
         PERM_WAIT: begin
            if (bus.perm_out_valid) begin
               st_d = bus.perm_state_in;
               if (padded_q) begin
                  fsm_d = SQUEEZE;
               end else if (fin_q) begin
                  idx_d = '0;
                  fsm_d = PAD;
               end else begin
                  fsm_d = ABSORB;
               end
            end
         end
         SQUEEZE: begin
            if (bus.out_ready) begin
               if (oidx_q == DIG_LAST) begin
                  st_d     = '0;
                  idx_d    = '0;
                  oidx_d   = '0;
                  fin_d    = 1'b0;
                  padded_d = 1'b0;
                  fsm_d    = ABSORB;
               end else begin
                  oidx_d = oidx_q + 1'b1;
               end
            end
         end
         default: begin
            fsm_d = ABSORB;
         end
      endcase
   end

   assign bus.in_ready       = (fsm_q == ABSORB);
   assign bus.perm_in_valid  = (fsm_q == PERM_ISSUE);
   assign bus.perm_state_out = st_q;
   assign bus.out_valid      = (fsm_q == SQUEEZE);
   assign bus.out_last       = (fsm_q == SQUEEZE) && (oidx_q == DIG_LAST);
   assign bus.out_data       = (fsm_q == SQUEEZE) ? st_q[oidx_q] : '0;
   assign bus.busy           = !((fsm_q == ABSORB) && (idx_q == '0) && (st_q == '0));

endmodule
